float_mul_operand_queue: RTL and testbench
==========================================

Name: float_mul_operand_queue

Overview:
- Upstream feeder stage for the combinational floating-point multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a DEPTH-entry FIFO.
- At write time it classifies each operand. It also precomputes the special-case result: zero, infinity, NaN, or subnormal under DAZ.
- The multiplier's normal-path result is used only when out_special_o is 0. Downstream muxes the multiplier output against out_special_result_o.

Parameters:
- fp_t, fp_pkg::fp16_t, floating-point type with fields sig, exp, man.
- DEPTH, 4, FIFO entries. Must be a power of 2 and >= 2; elaboration error otherwise.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- in_opa_i  input  $bits(fp_t)  operand A.
- in_opb_i  input  $bits(fp_t)  operand B.
- in_valid_i  input  1  input pair valid.
- in_ready_o  output  1  queue can accept a pair.
- out_opa_o  output  $bits(fp_t)  head operand A.
- out_opb_o  output  $bits(fp_t)  head operand B.
- out_cls_a_o  output  3  class of head A (fp_class_e).
- out_cls_b_o  output  3  class of head B (fp_class_e).
- out_special_o  output  1  head pair needs the special-result bypass.
- out_special_result_o  output  $bits(fp_t)  bypass result for the head pair.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  consumer accepts the head entry.
- count_o  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, and may be asserted at any cycle. It discards all stored entries.
  - In the cycle after rst_i is sampled high: wr_ptr=0, rd_ptr=0, count_o=0, out_valid_o=0, and all out_* data outputs are 0.
  - While rst_i is high, in_ready_o=0.
- Flow control:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = (count_o != DEPTH) & !rst_i. There is no combinational path from out_ready_i to in_ready_o. When the queue is full, a same-cycle pop does not enable a push.
  - out_valid_o = (count_o != 0).
- Latency: a pair pushed into an empty queue appears at the head on the next cycle. There is no fall-through.
- Counter and pointers:
  - count_o increments on push only, decrements on pop only, and is unchanged on push&pop.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Out-of-range conditions: push while full or pop while empty cannot occur because it is gated by the handshake. A bench assertion checks that in_valid_i never causes count_o > DEPTH.
- Empty queue: all out_* data outputs read 0.
- Data stability: head data must not change while out_valid_o=1 and out_ready_i=0.
- Classification (fp_class_e), computed per operand before storage:
  - ZERO: exp=0 and man=0.
  - SUBN: exp=0 and man!=0.
  - NORM: exp in 1..MAX_EXP-1.
  - INF: exp=MAX_EXP and man=0.
  - NAN: exp=MAX_EXP and man!=0.
- Special result; s = opa.sig ^ opb.sig. Rules in priority order:
  1. Either operand NAN, or ZERO×INF (either order): canonical NaN {sig 0, exp all 1, man all 1}.
  2. Either operand INF: {s, MAX_EXP, 0}.
  3. Either operand ZERO: {s, 0, 0}.
  4. Otherwise: out_special_o=0 and out_special_result_o=0.
- Storage: class codes, the special flag and the special result are stored per entry alongside the operands. They are not recomputed at read time.

Optional Feature:
- Macro: FLOAT_MUL_OPQ_DAZ_EN.
- Defined: a SUBN operand is treated as ZERO in the special-result rules, so NAN and INF still take precedence. Its reported class remains SUBN.
  - Example: SUBN×NORM yields a special zero with sign s.
  - Example: SUBN×INF yields NaN.
- Undefined: a SUBN operand does not trigger the special path by itself. out_special_o follows only the NAN, INF and ZERO rules.

Decomposition:
- fp_pkg additions:
  - fp_class_e, a 3-bit enum: ZERO=0, SUBN=1, NORM=2, INF=3, NAN=4.
  - Canonical-NaN constant function.
- Sub-module float_classify: combinational. Takes fp_t and outputs fp_class_e. Instantiated twice on the write side.
- Special-result logic and the FIFO stay in this module.

Test Plan (fp16):
- Reset, then push {0x3C00, 0x4000} with out_ready_i=0:
  - Next cycle: out_valid_o=1, count_o=1.
  - cls A=NORM, cls B=NORM.
  - out_special_o=0, out_special_result_o=0.
- Push 4 pairs with out_ready_i=0:
  - in_ready_o=0 at count_o=4.
  - A 5th push attempt is ignored.
  - After draining, data pops in push order and count_o returns to 0.
- Special cases:
  - {0x7C00, 0x0000}: special=1, result 0x7FFF.
  - {0xFC00, 0x4000}: result 0xFC00.
  - {0x8000, 0x3C00}: result 0x8000.
  - {0x7E00, 0x3C00}: result 0x7FFF.
- Simultaneous push and pop at count_o=2 for 10 cycles:
  - count_o stays 2.
  - Ordering preserved across pointer wrap.
- Input {0x0001, 0x3C00}:
  - With DAZ: special=1, result 0x0000, cls A=SUBN.
  - Without DAZ: special=0.
- Assert rst_i with 3 entries stored:
  - Next cycle: count_o=0, out_valid_o=0, outputs 0.
  - in_ready_o=0 during reset and 1 after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Floating-point types, operand class codes and the canonical NaN used by the
// multiplier feeder path.
package fp_pkg;

   typedef struct packed {
      logic       sig;
      logic [4:0] exp;
      logic [9:0] man;
   } fp16_t;

   typedef enum logic [2:0] {
      FP_ZERO = 3'd0,
      FP_SUBN = 3'd1,
      FP_NORM = 3'd2,
      FP_INF  = 3'd3,
      FP_NAN  = 3'd4
   } fp_class_e;

   // Positive sign, all-ones exponent and mantissa.
   function automatic fp16_t fp16_canonical_nan();
      fp16_t r;
      r.sig = 1'b0;
      r.exp = '1;
      r.man = '1;
      return r;
   endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational operand classifier: zero, subnormal, normal, infinity or NaN.
module float_classify
   import fp_pkg::*;
#(
   parameter type fp_t = fp_pkg::fp16_t
) (
   input  fp_t       op_i,
   output fp_class_e cls_o
);

   always_comb begin
      cls_o = FP_NORM;
      if (op_i.exp == '0) begin
         cls_o = (op_i.man == '0) ? FP_ZERO : FP_SUBN;
      end else if (op_i.exp == '1) begin
         cls_o = (op_i.man == '0) ? FP_INF : FP_NAN;
      end
   end

endmodule

// File: rtl/float_mul_operand_queue.sv
// Operand FIFO feeding the floating-point multiplier; classifies operands and
// precomputes the special-case result at write time. Define
// FLOAT_MUL_OPQ_DAZ_EN to treat subnormal operands as zero in special results.
module float_mul_operand_queue
   import fp_pkg::*;
#(
   parameter type fp_t  = fp_pkg::fp16_t,
   parameter int  DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  fp_t        in_opa_i,
   input  fp_t        in_opb_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output fp_t        out_opa_o,
   output fp_t        out_opb_o,
   output logic [2:0] out_cls_a_o,
   output logic [2:0] out_cls_b_o,
   output logic       out_special_o,
   output fp_t        out_special_result_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("float_mul_operand_queue: DEPTH must be a power of 2 and >= 2");
   end

   typedef struct packed {
      fp_t       opa;
      fp_t       opb;
      fp_class_e cls_a;
      fp_class_e cls_b;
      logic      special;
      fp_t       result;
   } entry_t;

   fp_class_e cls_a;
   fp_class_e cls_b;

   float_classify #(.fp_t(fp_t)) u_cls_a (.op_i(in_opa_i), .cls_o(cls_a));
   float_classify #(.fp_t(fp_t)) u_cls_b (.op_i(in_opb_i), .cls_o(cls_b));

   logic   any_nan;
   logic   any_inf;
   logic   a_zero;
   logic   b_zero;
   logic   sgn;
   entry_t wr_entry;

   // Priority: NaN (incl. zero x inf), then infinity, then zero.
   always_comb begin
      any_nan = (cls_a == FP_NAN) || (cls_b == FP_NAN);
      any_inf = (cls_a == FP_INF) || (cls_b == FP_INF);
`ifdef FLOAT_MUL_OPQ_DAZ_EN
      a_zero  = (cls_a == FP_ZERO) || (cls_a == FP_SUBN);
      b_zero  = (cls_b == FP_ZERO) || (cls_b == FP_SUBN);
`else
      a_zero  = (cls_a == FP_ZERO);
      b_zero  = (cls_b == FP_ZERO);
`endif
      sgn     = in_opa_i.sig ^ in_opb_i.sig;

      wr_entry         = '0;
      wr_entry.opa     = in_opa_i;
      wr_entry.opb     = in_opb_i;
      wr_entry.cls_a   = cls_a;
      wr_entry.cls_b   = cls_b;
      if (any_nan || (a_zero && cls_b == FP_INF) || (cls_a == FP_INF && b_zero)) begin
         wr_entry.special    = 1'b1;
         wr_entry.result.sig = 1'b0;
         wr_entry.result.exp = '1;
         wr_entry.result.man = '1;
      end else if (any_inf) begin
         wr_entry.special    = 1'b1;
         wr_entry.result.sig = sgn;
         wr_entry.result.exp = '1;
      end else if (a_zero || b_zero) begin
         wr_entry.special    = 1'b1;
         wr_entry.result.sig = sgn;
      end
   end

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push;
   logic            pop;
   entry_t          head;

   // in_ready_o depends only on occupancy and reset, never on out_ready_i.
   assign in_ready_o  = (count_q != FULL_CNT) && !rst_i;
   assign out_valid_o = (count_q != '0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_entry;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever empty.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_comb begin
      head = '0;
      if (out_valid_o) begin
         head = mem_q[rd_ptr_q];
      end
   end

   assign out_opa_o            = head.opa;
   assign out_opb_o            = head.opb;
   assign out_cls_a_o          = head.cls_a;
   assign out_cls_b_o          = head.cls_b;
   assign out_special_o        = head.special;
   assign out_special_result_o = head.result;
   assign count_o              = count_q;

endmodule

// File: tb/tb_float_mul_operand_queue.sv
// Directed bench for the multiplier operand queue (DEPTH 4, fp16).
module tb_float_mul_operand_queue;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] in_opa_i;
   logic [15:0] in_opb_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [15:0] out_opa_o;
   logic [15:0] out_opb_o;
   logic [2:0]  out_cls_a_o;
   logic [2:0]  out_cls_b_o;
   logic        out_special_o;
   logic [15:0] out_special_result_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [2:0]  count_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk_i = ~clk_i;

   float_mul_operand_queue #(.DEPTH(4)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .in_opa_i(in_opa_i),
      .in_opb_i(in_opb_i),
      .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o),
      .out_opa_o(out_opa_o),
      .out_opb_o(out_opb_o),
      .out_cls_a_o(out_cls_a_o),
      .out_cls_b_o(out_cls_b_o),
      .out_special_o(out_special_o),
      .out_special_result_o(out_special_result_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .count_o(count_o)
   );

   always @(negedge clk_i) begin
      if (rst_i === 1'b0) begin
         n_checks++;
         if (count_o > 3'd4) begin
            n_errors++;
            $display("FAIL overflow: count_o=%0d exceeds 4", count_o);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_idle();
      in_valid_i  = 1'b0;
      in_opa_i    = '0;
      in_opb_i    = '0;
      out_ready_i = 1'b0;
   endtask

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
      in_opa_i   = a;
      in_opb_i   = b;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
   endtask

   task automatic pop_one();
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      n_checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL %s empty: count=%0d valid=%b, want 0/0", tag, count_o, out_valid_o);
      end
      n_checks++;
      if ({out_opa_o, out_opb_o, out_cls_a_o, out_cls_b_o, out_special_o, out_special_result_o} !== '0) begin
         n_errors++;
         $display("FAIL %s zero_data: opa=%h opb=%h cls=%0d/%0d sp=%b res=%h, want all 0",
                  tag, out_opa_o, out_opb_o, out_cls_a_o, out_cls_b_o, out_special_o, out_special_result_o);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      rst_i = 1'b1;
      step();
      step();
      n_checks++;
      if (in_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ready: in_ready_o=%b, want 0", in_ready_o);
      end
      check_empty("reset");
      rst_i = 1'b0;
      step();
      n_checks++;
      if (in_ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_ready: in_ready_o=%b, want 1", in_ready_o);
      end
   endtask

   task automatic test_single();
      push_pair(16'h3C00, 16'h4000);
      n_checks++;
      if (out_valid_o !== 1'b1 || count_o !== 3'd1) begin
         n_errors++;
         $display("FAIL single_valid: valid=%b count=%0d, want 1/1", out_valid_o, count_o);
      end
      n_checks++;
      if (out_opa_o !== 16'h3C00 || out_opb_o !== 16'h4000) begin
         n_errors++;
         $display("FAIL single_data: opa=%h opb=%h, want 3c00/4000", out_opa_o, out_opb_o);
      end
      n_checks++;
      if (out_cls_a_o !== 3'd2 || out_cls_b_o !== 3'd2) begin
         n_errors++;
         $display("FAIL single_cls: cls=%0d/%0d, want 2/2", out_cls_a_o, out_cls_b_o);
      end
      n_checks++;
      if (out_special_o !== 1'b0 || out_special_result_o !== 16'h0000) begin
         n_errors++;
         $display("FAIL single_special: sp=%b res=%h, want 0/0000", out_special_o, out_special_result_o);
      end
      step();
      n_checks++;
      if (out_opa_o !== 16'h3C00 || count_o !== 3'd1) begin
         n_errors++;
         $display("FAIL single_hold: opa=%h count=%0d, want 3c00/1", out_opa_o, count_o);
      end
      pop_one();
      check_empty("single_drain");
   endtask

   task automatic test_full();
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         e = {16'h3C00 + 16'(i), 16'h4400 + 16'(i * 3)};
         exp_q.push_back(e);
         push_pair(e[31:16], e[15:0]);
      end
      n_checks++;
      if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL full_ready: count=%0d ready=%b, want 4/0", count_o, in_ready_o);
      end
      push_pair(16'h5555, 16'h5555);
      n_checks++;
      if (count_o !== 3'd4) begin
         n_errors++;
         $display("FAIL full_ignore: count=%0d, want 4", count_o);
      end
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({out_opa_o, out_opb_o} !== e) begin
            n_errors++;
            $display("FAIL full_order[%0d]: got %h, want %h", i, {out_opa_o, out_opb_o}, e);
         end
         pop_one();
      end
      check_empty("full_drain");
   endtask

   task automatic test_special();
      logic [15:0] va [6] = '{16'h7C00, 16'h0000, 16'hFC00, 16'h8000, 16'h7E00, 16'h3C00};
      logic [15:0] vb [6] = '{16'h0000, 16'h7C00, 16'h4000, 16'h3C00, 16'h3C00, 16'hFE00};
      logic [15:0] vr [6] = '{16'h7FFF, 16'h7FFF, 16'hFC00, 16'h8000, 16'h7FFF, 16'h7FFF};
      logic [2:0]  ca [6] = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd4, 3'd2};
      logic [2:0]  cb [6] = '{3'd0, 3'd3, 3'd2, 3'd2, 3'd2, 3'd4};
      for (int i = 0; i < 6; i++) begin
         push_pair(va[i], vb[i]);
         n_checks++;
         if (out_special_o !== 1'b1 || out_special_result_o !== vr[i]) begin
            n_errors++;
            $display("FAIL special[%0d]: sp=%b res=%h, want 1/%h", i, out_special_o, out_special_result_o, vr[i]);
         end
         n_checks++;
         if (out_cls_a_o !== ca[i] || out_cls_b_o !== cb[i]) begin
            n_errors++;
            $display("FAIL special_cls[%0d]: cls=%0d/%0d, want %0d/%0d", i, out_cls_a_o, out_cls_b_o, ca[i], cb[i]);
         end
         pop_one();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      for (int i = 0; i < 2; i++) begin
         e = {16'h4000 + 16'(i), 16'h4800 + 16'(i)};
         exp_q.push_back(e);
         push_pair(e[31:16], e[15:0]);
      end
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (count_o !== 3'd2 || {out_opa_o, out_opb_o} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL b2b[%0d]: count=%0d head=%h, want 2/%h", k, count_o, {out_opa_o, out_opb_o}, exp_q[0]);
         end
         e = {16'h4000 + 16'(k + 2), 16'h4800 + 16'(k + 2)};
         in_opa_i    = e[31:16];
         in_opb_i    = e[15:0];
         in_valid_i  = 1'b1;
         out_ready_i = 1'b1;
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(e);
      end
      drive_idle();
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({out_opa_o, out_opb_o} !== e) begin
            n_errors++;
            $display("FAIL b2b_drain[%0d]: got %h, want %h", i, {out_opa_o, out_opb_o}, e);
         end
         pop_one();
      end
      check_empty("b2b_drain");
   endtask

   task automatic test_daz();
      push_pair(16'h0001, 16'h3C00);
      n_checks++;
      if (out_cls_a_o !== 3'd1) begin
         n_errors++;
         $display("FAIL daz_cls: cls_a=%0d, want 1", out_cls_a_o);
      end
      n_checks++;
`ifdef FLOAT_MUL_OPQ_DAZ_EN
      if (out_special_o !== 1'b1 || out_special_result_o !== 16'h0000) begin
         n_errors++;
         $display("FAIL daz_norm: sp=%b res=%h, want 1/0000", out_special_o, out_special_result_o);
      end
`else
      if (out_special_o !== 1'b0 || out_special_result_o !== 16'h0000) begin
         n_errors++;
         $display("FAIL daz_norm: sp=%b res=%h, want 0/0000", out_special_o, out_special_result_o);
      end
`endif
      pop_one();
      push_pair(16'h8001, 16'h7C00);
      n_checks++;
`ifdef FLOAT_MUL_OPQ_DAZ_EN
      if (out_special_o !== 1'b1 || out_special_result_o !== 16'h7FFF) begin
         n_errors++;
         $display("FAIL daz_inf: sp=%b res=%h, want 1/7fff", out_special_o, out_special_result_o);
      end
`else
      if (out_special_o !== 1'b1 || out_special_result_o !== 16'hFC00) begin
         n_errors++;
         $display("FAIL daz_inf: sp=%b res=%h, want 1/fc00", out_special_o, out_special_result_o);
      end
`endif
      pop_one();
   endtask

   task automatic test_reset_mid();
      push_pair(16'h3C00, 16'h3C00);
      push_pair(16'h4000, 16'h4000);
      push_pair(16'h4200, 16'h4200);
      n_checks++;
      if (count_o !== 3'd3) begin
         n_errors++;
         $display("FAIL mid_fill: count=%0d, want 3", count_o);
      end
      rst_i = 1'b1;
      step();
      n_checks++;
      if (in_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_rst_ready: in_ready_o=%b, want 0", in_ready_o);
      end
      check_empty("mid_reset");
      rst_i = 1'b0;
      step();
      n_checks++;
      if (in_ready_o !== 1'b1 || count_o !== 3'd0) begin
         n_errors++;
         $display("FAIL mid_release: ready=%b count=%0d, want 1/0", in_ready_o, count_o);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      drive_idle();
      test_reset();
      test_single();
      test_full();
      test_special();
      test_back_to_back();
      test_daz();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
